// File: rtl/button_debounce_pkg.sv
// Shared constants and types for the pushbutton debouncer.
package debounce_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned COUNT_WIDTH   = 8;

  // What the debouncer does on the coming edge, decided from S, O and CNT.
  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_COUNT,
    ACT_UPDATE
  } act_e;

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between a pushbutton source and the debouncer.
interface button_debounce_if;

  logic                                i;
  logic                                o;
  logic                                rise;
  logic                                fall;
  logic [debounce_pkg::COUNT_WIDTH-1:0] count;

  modport master (output i, input o, rise, fall, count);
  modport slave  (input i, output o, rise, fall, count);

endinterface

// File: rtl/button_debounce_sync.sv
// Two-flop synchronizer bringing the raw button pin into the CLK domain.
module sync_ff2 (
  input  logic CLK,
  input  logic RESETN,
  input  logic I,
  output logic O
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = I;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses <= so both stages sample the pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign O = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounced button level with registered rise/fall pulses and a press counter.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   I,
  output logic                   O,
  output logic                   RISE,
  output logic                   FALL,
  output logic [COUNT_WIDTH-1:0] COUNT
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic                   s;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  act_e                   act;

  sync_ff2 u_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .I      (I),
    .O      (s)
  );

  always_comb begin
    if (s == o_q)          act = ACT_IDLE;
    else if (cnt_q != MAX) act = ACT_COUNT;
    else                   act = ACT_UPDATE;
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    cnt_d   = '0;
    o_d     = o_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    unique case (act)
      ACT_IDLE:  ;
      ACT_COUNT: cnt_d = cnt_q + 1'b1;
      ACT_UPDATE: begin
        // CNT is left at its zero default, so it never wraps past MAX.
        o_d    = s;
        rise_d = s;
        fall_d = ~s;
        if (s) count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt_q   <= '0;
      o_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign O     = o_q;
  assign RISE  = rise_q;
  assign FALL  = fall_q;
  assign COUNT = count_q;

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter WIDTH, default 16, is the debounce counter width; the stable-time threshold is MAX = 2^WIDTH-1.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RESETN  input  1  reset; synchronous, active-low.
REQ-004 I  input  1  raw pushbutton pin, asynchronous to CLK, may bounce.
REQ-005 O  output  1  debounced level of I.
REQ-006 RISE  output  1  single-cycle pulse, high in the cycle O goes 0->1.
REQ-007 FALL  output  1  single-cycle pulse, high in the cycle O goes 1->0.
REQ-008 COUNT  output  8  number of accepted rising edges, modulo 256.

Function
REQ-009 I shall pass through a two-flop synchronizer; the second-stage output S is the only internal use of I.
REQ-010 Each edge when S == O: counter CNT <= 0; O, COUNT unchanged; RISE = FALL = 0 next cycle.
REQ-011 Each edge when S != O and CNT != MAX: CNT <= CNT+1; O unchanged.
REQ-012 Each edge when S != O and CNT == MAX: O <= S; CNT <= 0; RISE <= S; FALL <= !S.
REQ-013 RISE and FALL are registered, asserted only in the cycle after the O-update edge, and never high simultaneously.
REQ-014 Latency: if edge k is the first edge sampling a new stable I level, O changes on edge k+MAX+2, so WIDTH=4 gives k+17.
REQ-015 An I level held for fewer than MAX+1 consecutive cycles of S != O shall not change O and shall produce no pulse.
REQ-016 Any return of S to O before the threshold shall clear CNT, so the stable time must restart from zero.
REQ-017 COUNT increments by 1 on each edge that sets O from 0 to 1, and wraps 255 -> 0 with no flag.
REQ-018 The CNT increment shall not overflow, because REQ-012 resets CNT at MAX.
REQ-019 FALL has no effect on COUNT.

Reset
REQ-020 On an edge with RESETN=0: both synchronizer flops, CNT, O, RISE, FALL and COUNT shall all be set to 0.
REQ-021 Reset overrides all function rules on the same edge.
REQ-022 Reset mid-count discards partial progress.
REQ-023 If I=1 at reset release, O rises after the REQ-014 latency with RISE and a COUNT increment.

Structure
REQ-024 Package debounce_pkg shall hold the default WIDTH and the COUNT width constant (8).
REQ-025 The synchronizer shall be a sub-module sync_ff2, with ports CLK, RESETN, I, O and two flops reset to 0.
REQ-026 All remaining logic (counter, compare, output/pulse/COUNT registers) shall live in button_debounce.
REQ-027 The block shall have no other clocks and no latches.

Verification (WIDTH=4, MAX=15)
REQ-028 Reset: RESETN=0 for 3 edges with I=1 -> O=0, RISE=0, FALL=0, COUNT=0.
REQ-029 Clean press: I 0->1, first sampled at edge k, held -> O=1 at k+17; RISE high exactly one cycle; COUNT=1; FALL never high.
REQ-030 Glitch: I=1 for 10 cycles, then 0 -> O stays 0, no RISE, COUNT=0.
REQ-031 Bounce: I toggles every 3 cycles for 30 cycles, then held 1 from edge j -> exactly one RISE; O=1 at j+17; COUNT=1.
REQ-032 Wrap: 256 clean press/release cycles -> 256 RISE and 256 FALL pulses; COUNT back to 0.
REQ-033 Reset mid-count: I=1 for 10 cycles, then RESETN=0 for 1 edge -> O=0, CNT=0.
REQ-034 After release in REQ-033 (first sampling edge r) -> O=1 at r+17; COUNT=1.
